// File: rtl/tspp_types_pkg.sv
// Shared types for the two-stage pipeline: machine word and hazard controller states.
package tspp_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT_WAIT,
    HALTED
  } hazard_state_t;

endpackage

// File: rtl/tspp_perf_counter.sv
// Enable-driven event counter; wraps modulo 2^WIDTH, synchronous clear wins over enable.
module tspp_perf_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tspp_hazard_ctrl.sv
// Hazard/redirect controller: arbitrates execute redirects, holds them across
// in-flight instruction fetches, implements halt and counts stall/redirect events.
module tspp_hazard_ctrl
  import tspp_types_pkg::*;
#(
  parameter int unsigned PERF_CNT_W   = 32,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_mem_busy,
  input  logic                  d_mem_busy,
  input  logic                  exception,
  input  word_t                 ex_pc,
  input  word_t                 trap_vector,
  input  logic                  mret,
  input  word_t                 mepc,
  input  logic                  jump,
  input  word_t                 jump_addr,
  input  logic                  branch_taken,
  input  word_t                 branch_addr,
  input  logic                  halt,
  output logic                  update_pc,
  output word_t                 update_addr,
  output logic                  flush,
  output logic                  stall,
  output logic                  epc_wen,
  output word_t                 epc_out,
  output logic                  halted,
  output logic                  timeout_err,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] redirect_count
);

  hazard_state_t state, next_state;
  word_t         pending_addr;
  logic [31:0]   wait_cnt;
  logic          timeout_q;

  logic  sample;
  logic  req_exc, req_mret, req_jump, req_br, req_halt, redirect_req;
  word_t target;

  logic [PERF_CNT_W-1:0] stall_cnt, redir_cnt;

  // Execute holds its inputs while a data access is in flight, so requests only count when it is idle.
  assign sample       = !RST && !d_mem_busy;
  assign req_exc      = sample && exception;
  assign req_mret     = sample && mret && !exception;
  assign req_jump     = sample && jump && !exception && !mret;
  assign req_br       = sample && branch_taken && !exception && !mret && !jump;
  assign req_halt     = sample && halt && !exception && !mret && !jump && !branch_taken;
  assign redirect_req = req_exc || req_mret || req_jump || req_br;

  always_comb begin
    target = '0;
    if (req_exc)       target = trap_vector;
    else if (req_mret) target = mepc;
    else if (req_jump) target = jump_addr;
    else if (req_br)   target = branch_addr;
  end

  always_comb begin
    next_state  = state;
    update_pc   = 1'b0;
    update_addr = '0;
    flush       = 1'b0;
    epc_wen     = 1'b0;
    halted      = 1'b0;
    if (!RST) begin
      unique case (state)
        RUN: begin
          if (redirect_req) begin
            flush       = 1'b1;
            epc_wen     = req_exc;
            update_addr = target;
            if (!i_mem_busy) update_pc = 1'b1;
            else             next_state = REDIRECT_WAIT;
          end else if (req_halt) begin
            next_state = HALTED;
          end
        end
        REDIRECT_WAIT: begin
          flush       = 1'b1;
          epc_wen     = req_exc;
          update_addr = pending_addr;
          if (!i_mem_busy) begin
            update_pc  = 1'b1;
            // A trap arriving on the release cycle must not lose to the stale pending target.
            if (req_exc) update_addr = trap_vector;
            next_state = RUN;
          end
        end
        HALTED: begin
          flush  = 1'b1;
          halted = 1'b1;
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign epc_out        = epc_wen ? ex_pc : '0;
  assign stall          = !RST && (d_mem_busy || state == HALTED);
  assign timeout_err    = !RST && timeout_q;
  assign stall_cycles   = RST ? '0 : stall_cnt;
  assign redirect_count = RST ? '0 : redir_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      pending_addr <= '0;
      wait_cnt     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RUN && redirect_req && i_mem_busy) begin
        pending_addr <= target;
      end else if (state == REDIRECT_WAIT && req_exc) begin
        pending_addr <= trap_vector;
      end
      if (state == REDIRECT_WAIT && next_state == REDIRECT_WAIT) wait_cnt <= wait_cnt + 32'd1;
      else                                                       wait_cnt <= '0;
      if (WAIT_TIMEOUT != 0 && state == REDIRECT_WAIT && (wait_cnt + 32'd1) == WAIT_TIMEOUT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Execute must present a bubble while a redirect is waiting; only a trap may arrive.
  assert property (@(posedge CLK) disable iff (RST)
    (state == REDIRECT_WAIT && !d_mem_busy) |-> !(mret || jump || branch_taken || halt));

  tspp_perf_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .en    (stall),
    .count (stall_cnt)
  );

  tspp_perf_counter #(.WIDTH(PERF_CNT_W)) u_redir_cnt (
    .clk   (CLK),
    .clr   (RST),
    .en    (update_pc),
    .count (redir_cnt)
  );

endmodule
